vector_clipper: RTL and testbench

- Sits between the AVG vector decoder's line outputs (start/end/intensity plus lrWrite strobe) and the line register queue that feeds the rasterizer.
- Clips each 13-bit signed line segment to the visible raster window using iterative midpoint subdivision; no divider is used.
- Discards lines that are invisible or blank.
- Exposes a valid/ready handshake on both sides so the queue's full flag back-pressures the decoder.

---
 rtl/vector_clipper_pkg.sv | 32 +++
 rtl/vc_outcode.sv | 27 ++
 rtl/vector_clipper.sv | 226 ++++++++++++++++++++++
 tb/tb_vector_clipper.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_clipper_pkg.sv
// Shared definitions for the vector clipper slice.
// Purpose: window defaults matching the 640x480 VGA raster, the outcode
// layout used for Cohen-Sutherland style classification, and the FSM states.
// Ports: none (package).
package vector_clipper_pkg;

  // Default visible window, inclusive on every edge.
  localparam logic signed [12:0] WIN_XMIN = 13'sd0;
  localparam logic signed [12:0] WIN_XMAX = 13'sd639;
  localparam logic signed [12:0] WIN_YMIN = 13'sd0;
  localparam logic signed [12:0] WIN_YMAX = 13'sd479;

  // Upper bound on subdivision steps spent on a single endpoint.
  localparam int ITER_MAX_DEFAULT = 14;

  // One bit per window edge the point lies beyond; all-zero means visible.
  typedef struct packed {
    logic top;
    logic bottom;
    logic right;
    logic left;
  } outcode_t;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    CLIP_A,
    CLIP_B,
    EMIT
  } state_t;

endpackage

// File: rtl/vc_outcode.sv
// Combinational outcode generator.
// Purpose: classify one signed 13-bit point against the inclusive window.
// Ports:
//   x_i, y_i  : signed point coordinates
//   code_o    : {top,bottom,right,left}, set when the point is beyond that edge
module vc_outcode
  import vector_clipper_pkg::*;
#(
  parameter logic signed [12:0] XMIN = WIN_XMIN,
  parameter logic signed [12:0] XMAX = WIN_XMAX,
  parameter logic signed [12:0] YMIN = WIN_YMIN,
  parameter logic signed [12:0] YMAX = WIN_YMAX
) (
  input  logic signed [12:0] x_i,
  input  logic signed [12:0] y_i,
  output outcode_t           code_o
);

  // Edge pixels count as inside, so only strict comparisons set a bit.
  always_comb begin
    code_o.top    = (y_i < YMIN);
    code_o.bottom = (y_i > YMAX);
    code_o.right  = (x_i > XMAX);
    code_o.left   = (x_i < XMIN);
  end

endmodule

// File: rtl/vector_clipper.sv
// Line clipper between the AVG vector decoder and the line register queue.
// Purpose: trivially accept/reject each line, otherwise move the outside
// endpoint(s) onto the window by midpoint subdivision, then hand the line on.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid / in_ready       : upstream handshake (lrWrite / halt)
//   in_start_*, in_end_*      : signed 13-bit endpoints, in_intensity 4-bit
//   out_valid / out_ready     : downstream handshake (out_ready = ~queue full)
//   out_start_*, out_end_*    : clipped endpoints, out_intensity passed through
//   busy                      : a line is being clipped or held for output
//   cnt_accept/clip/reject    : wrapping 16-bit statistics
module vector_clipper
  import vector_clipper_pkg::*;
#(
  parameter logic signed [12:0] XMIN       = WIN_XMIN,
  parameter logic signed [12:0] XMAX       = WIN_XMAX,
  parameter logic signed [12:0] YMIN       = WIN_YMIN,
  parameter logic signed [12:0] YMAX       = WIN_YMAX,
  parameter int                 ITER_MAX   = ITER_MAX_DEFAULT,
  parameter bit                 DROP_BLANK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [12:0] in_start_x,
  input  logic signed [12:0] in_start_y,
  input  logic signed [12:0] in_end_x,
  input  logic signed [12:0] in_end_y,
  input  logic [3:0]         in_intensity,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [12:0] out_start_x,
  output logic signed [12:0] out_start_y,
  output logic signed [12:0] out_end_x,
  output logic signed [12:0] out_end_y,
  output logic [3:0]         out_intensity,
  output logic               busy,
  output logic [15:0]        cnt_accept,
  output logic [15:0]        cnt_clip,
  output logic [15:0]        cnt_reject
);

  state_t             state_q;
  logic signed [12:0] startX_q, startY_q, endX_q, endY_q;
  logic [3:0]         intensity_q;
  // Working pair: a is the endpoint being pulled in, b is the far point.
  logic signed [12:0] aX_q, aY_q, bX_q, bY_q;
  outcode_t           codeEnd_q;
  logic [7:0]         iter_q;
  logic               inReady_q, outValid_q, busy_q;
  logic [15:0]        acceptCnt_q, clipCnt_q, rejectCnt_q;

  outcode_t           codeA, codeB, codeM, codeNextB_d;
  logic signed [13:0] sumX_d, sumY_d, diffX_d, diffY_d;
  logic signed [12:0] mX_d, mY_d;
  logic signed [12:0] nextAX_d, nextAY_d, nextBX_d, nextBY_d;
  logic               moveA_d, close_d, stepDone_d;

  vc_outcode #(.XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)) uCodeA (
    .x_i(aX_q), .y_i(aY_q), .code_o(codeA)
  );
  vc_outcode #(.XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)) uCodeB (
    .x_i(bX_q), .y_i(bY_q), .code_o(codeB)
  );
  vc_outcode #(.XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)) uCodeM (
    .x_i(mX_d), .y_i(mY_d), .code_o(codeM)
  );

  // One subdivision step on the working pair. The midpoint uses a 14-bit sum
  // and an arithmetic shift so it floors toward minus infinity. If the
  // midpoint still shares an outside edge with a, the crossing lies beyond it
  // and a moves; otherwise b moves. The code of the new b is picked from the
  // instances already present, so the step and its termination test both
  // complete in the same cycle.
  always_comb begin
    sumX_d      = {aX_q[12], aX_q} + {bX_q[12], bX_q};
    sumY_d      = {aY_q[12], aY_q} + {bY_q[12], bY_q};
    mX_d        = 13'(sumX_d >>> 1);
    mY_d        = 13'(sumY_d >>> 1);
    moveA_d     = ((codeA & codeM) != 4'b0000);
    nextAX_d    = moveA_d ? mX_d : aX_q;
    nextAY_d    = moveA_d ? mY_d : aY_q;
    nextBX_d    = moveA_d ? bX_q : mX_d;
    nextBY_d    = moveA_d ? bY_q : mY_d;
    codeNextB_d = moveA_d ? codeB : codeM;
    diffX_d     = {nextAX_d[12], nextAX_d} - {nextBX_d[12], nextBX_d};
    diffY_d     = {nextAY_d[12], nextAY_d} - {nextBY_d[12], nextBY_d};
    close_d     = (diffX_d >= -14'sd1) && (diffX_d <= 14'sd1) &&
                  (diffY_d >= -14'sd1) && (diffY_d <= 14'sd1);
    stepDone_d  = close_d || (iter_q == 8'(ITER_MAX - 1));
  end

  // Control FSM with registered handshake outputs and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      startX_q    <= '0;
      startY_q    <= '0;
      endX_q      <= '0;
      endY_q      <= '0;
      intensity_q <= '0;
      aX_q        <= '0;
      aY_q        <= '0;
      bX_q        <= '0;
      bY_q        <= '0;
      codeEnd_q   <= '0;
      iter_q      <= '0;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      acceptCnt_q <= '0;
      clipCnt_q   <= '0;
      rejectCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            startX_q    <= in_start_x;
            startY_q    <= in_start_y;
            endX_q      <= in_end_x;
            endY_q      <= in_end_y;
            intensity_q <= in_intensity;
            aX_q        <= in_start_x;
            aY_q        <= in_start_y;
            bX_q        <= in_end_x;
            bY_q        <= in_end_y;
            inReady_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          codeEnd_q <= codeB;
          iter_q    <= '0;
          if (DROP_BLANK && (intensity_q == 4'd0)) begin
            inReady_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if ((codeA & codeB) != 4'b0000) begin
            rejectCnt_q <= rejectCnt_q + 16'd1;
            inReady_q   <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if ((codeA == 4'b0000) && (codeB == 4'b0000)) begin
            acceptCnt_q <= acceptCnt_q + 16'd1;
            outValid_q  <= 1'b1;
            state_q     <= EMIT;
          end else if (codeA != 4'b0000) begin
            state_q <= CLIP_A;
          end else begin
            // Only the end needs work: swap so a is always the moving point.
            aX_q    <= endX_q;
            aY_q    <= endY_q;
            bX_q    <= startX_q;
            bY_q    <= startY_q;
            state_q <= CLIP_B;
          end
        end
        CLIP_A, CLIP_B: begin
          aX_q   <= nextAX_d;
          aY_q   <= nextAY_d;
          bX_q   <= nextBX_d;
          bY_q   <= nextBY_d;
          iter_q <= iter_q + 8'd1;
          if (stepDone_d) begin
            if (codeNextB_d != 4'b0000) begin
              rejectCnt_q <= rejectCnt_q + 16'd1;
              inReady_q   <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else if ((state_q == CLIP_A) && (codeEnd_q != 4'b0000)) begin
              // Start is now inside; clip the end against the new start.
              startX_q <= nextBX_d;
              startY_q <= nextBY_d;
              aX_q     <= endX_q;
              aY_q     <= endY_q;
              bX_q     <= nextBX_d;
              bY_q     <= nextBY_d;
              iter_q   <= '0;
              state_q  <= CLIP_B;
            end else begin
              if (state_q == CLIP_A) begin
                startX_q <= nextBX_d;
                startY_q <= nextBY_d;
              end else begin
                endX_q <= nextBX_d;
                endY_q <= nextBY_d;
              end
              clipCnt_q  <= clipCnt_q + 16'd1;
              outValid_q <= 1'b1;
              state_q    <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = inReady_q;
  assign out_valid     = outValid_q;
  assign busy          = busy_q;
  assign out_start_x   = startX_q;
  assign out_start_y   = startY_q;
  assign out_end_x     = endX_q;
  assign out_end_y     = endY_q;
  assign out_intensity = intensity_q;
  assign cnt_accept    = acceptCnt_q;
  assign cnt_clip      = clipCnt_q;
  assign cnt_reject    = rejectCnt_q;

endmodule

// File: tb/tb_vector_clipper.sv
// Directed testbench for vector_clipper.
// Drives lines on the falling edge, samples on the falling edge, and compares
// against hand-derived endpoints, latencies and counter values.
module tb_vector_clipper;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [12:0] in_start_x, in_start_y, in_end_x, in_end_y;
  logic [3:0]         in_intensity;
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out_start_x, out_start_y, out_end_x, out_end_y;
  logic [3:0]         out_intensity;
  logic               busy;
  logic [15:0]        cnt_accept, cnt_clip, cnt_reject;

  int checkCount = 0;
  int errorCount = 0;

  bit                 sawValid;
  int                 latency;
  logic signed [12:0] holdSx, holdSy, holdEx, holdEy;

  vector_clipper dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_start_x(in_start_x), .in_start_y(in_start_y),
    .in_end_x(in_end_x), .in_end_y(in_end_y),
    .in_intensity(in_intensity),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_start_x(out_start_x), .out_start_y(out_start_y),
    .out_end_x(out_end_x), .out_end_y(out_end_y),
    .out_intensity(out_intensity),
    .busy(busy),
    .cnt_accept(cnt_accept), .cnt_clip(cnt_clip), .cnt_reject(cnt_reject)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so counts and reporting stay uniform.
  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one line for a single cycle, then wait (bounded) until either
  // out_valid appears or the block goes idle. Latency counts falling edges
  // after the capture edge, so a trivially accepted line reports 2.
  task automatic applyStimulus(input int sx, input int sy, input int ex, input int ey,
                               input int inten, output bit seen, output int lat);
    bit done;
    int k;
    @(negedge clk);
    in_valid     = 1'b1;
    in_start_x   = 13'(sx);
    in_start_y   = 13'(sy);
    in_end_x     = 13'(ex);
    in_end_y     = 13'(ey);
    in_intensity = 4'(inten);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("in_ready_low_after_capture", in_ready, 0);
    checkOutput("busy_after_capture", busy, 1);
    seen = 1'b0;
    lat  = 0;
    done = 1'b0;
    k    = 1;
    while (!done) begin
      if (out_valid) begin
        seen = 1'b1;
        lat  = k;
        done = 1'b1;
      end else if (!busy) begin
        done = 1'b1;
      end else if (k >= 60) begin
        checkOutput("line_timeout", busy, 0);
        done = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  // Compare the presented line, then let the handshake complete.
  task automatic checkLine(input string tag, input int sx, input int sy, input int ex,
                           input int ey, input int inten);
    checkOutput({tag, "_start_x"}, out_start_x, sx);
    checkOutput({tag, "_start_y"}, out_start_y, sy);
    checkOutput({tag, "_end_x"}, out_end_x, ex);
    checkOutput({tag, "_end_y"}, out_end_y, ey);
    checkOutput({tag, "_intensity"}, out_intensity, inten);
    @(negedge clk);
    checkOutput({tag, "_valid_dropped"}, out_valid, 0);
    checkOutput({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_start_x   = '0;
    in_start_y   = '0;
    in_end_x     = '0;
    in_end_y     = '0;
    in_intensity = '0;
    out_ready    = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_start_x", out_start_x, 0);
    checkOutput("reset_out_end_y", out_end_y, 0);
    checkOutput("reset_cnt_accept", cnt_accept, 0);
    checkOutput("reset_cnt_clip", cnt_clip, 0);
    checkOutput("reset_cnt_reject", cnt_reject, 0);
    rst = 1'b0;

    // Fully visible line: unchanged, two cycles after capture.
    applyStimulus(100, 100, 200, 300, 5, sawValid, latency);
    checkOutput("accept_seen", sawValid, 1);
    checkOutput("accept_latency", latency, 2);
    checkLine("accept", 100, 100, 200, 300, 5);
    checkOutput("accept_cnt_accept", cnt_accept, 1);

    // Start left of the window: start pulled to x=0 in 8 steps.
    applyStimulus(-100, 50, 100, 50, 9, sawValid, latency);
    checkOutput("left_seen", sawValid, 1);
    checkOutput("left_latency", latency, 10);
    checkLine("left", 0, 50, 100, 50, 9);
    checkOutput("left_cnt_clip", cnt_clip, 1);

    // Both endpoints right of the window: trivial reject.
    applyStimulus(700, 10, 800, 400, 2, sawValid, latency);
    checkOutput("reject_no_output", sawValid, 0);
    checkOutput("reject_cnt_reject", cnt_reject, 1);
    checkOutput("reject_cnt_accept", cnt_accept, 1);

    // Steep line that only touches the window at the origin corner.
    applyStimulus(-50, 600, 50, -600, 7, sawValid, latency);
    checkOutput("corner_seen", sawValid, 1);
    checkOutput("corner_latency", latency, 22);
    checkLine("corner", 0, 0, 0, 0, 7);
    checkOutput("corner_cnt_clip", cnt_clip, 2);

    // Vertical line through the window: start to bottom edge, end to top edge.
    applyStimulus(320, 600, 320, -100, 12, sawValid, latency);
    checkOutput("vertical_seen", sawValid, 1);
    checkOutput("vertical_latency", latency, 20);
    checkLine("vertical", 320, 479, 320, 0, 12);
    checkOutput("vertical_cnt_clip", cnt_clip, 3);

    // Blank line is dropped without touching any counter.
    applyStimulus(10, 10, 20, 20, 0, sawValid, latency);
    checkOutput("blank_no_output", sawValid, 0);
    checkOutput("blank_cnt_accept", cnt_accept, 1);
    checkOutput("blank_cnt_clip", cnt_clip, 3);
    checkOutput("blank_cnt_reject", cnt_reject, 1);

    // Edge pixels are inside: a line along the far corner is accepted as-is.
    applyStimulus(639, 479, 0, 0, 1, sawValid, latency);
    checkOutput("edge_latency", latency, 2);
    checkLine("edge", 639, 479, 0, 0, 1);
    checkOutput("edge_cnt_accept", cnt_accept, 2);

    // Back-pressure: hold out_ready low in EMIT while upstream keeps offering.
    out_ready = 1'b0;
    applyStimulus(100, 100, 200, 300, 3, sawValid, latency);
    checkOutput("stall_seen", sawValid, 1);
    holdSx = out_start_x;
    holdSy = out_start_y;
    holdEx = out_end_x;
    holdEy = out_end_y;
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'b1;
      in_start_x = 13'sd5;
      in_end_y   = 13'sd7;
      @(negedge clk);
      checkOutput("stall_valid_held", out_valid, 1);
      checkOutput("stall_in_ready_low", in_ready, 0);
      checkOutput("stall_start_x", out_start_x, 100);
      checkOutput("stall_end_y", out_end_y, 300);
    end
    checkOutput("stall_hold_sy", out_start_y, holdSy);
    checkOutput("stall_hold_ex", out_end_x, holdEx);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_valid", out_valid, 0);
    checkOutput("stall_release_in_ready", in_ready, 1);
    checkOutput("stall_cnt_accept", cnt_accept, 3);

    // Reset in the middle of CLIP_A aborts the line immediately.
    @(negedge clk);
    in_valid     = 1'b1;
    in_start_x   = -13'sd100;
    in_start_y   = 13'sd50;
    in_end_x     = 13'sd100;
    in_end_y     = 13'sd50;
    in_intensity = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midclip_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midclip_rst_out_valid", out_valid, 0);
    checkOutput("midclip_rst_in_ready", in_ready, 1);
    checkOutput("midclip_rst_cnt_clip", cnt_clip, 0);
    @(negedge clk);
    checkOutput("midclip_still_no_output", out_valid, 0);
    rst = 1'b0;

    // Block works normally after the abort.
    applyStimulus(100, 100, 200, 300, 5, sawValid, latency);
    checkOutput("after_rst_latency", latency, 2);
    checkLine("after_rst", 100, 100, 200, 300, 5);
    checkOutput("after_rst_cnt_accept", cnt_accept, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
